// File: rtl/coproc_pkg.sv
// Shared constants and types for the coprocessor scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package coproc_pkg;

    // Only opcode the coprocessor implements; every other code is rejected.
    localparam logic [1:0] OP_ADD      = 2'b01;
    localparam int         DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant among NREQ requesters, searching upward from i_ptr.
// Latency: purely combinational.
// Backpressure: none; the owner decides when a grant is taken.
// Ports: i_req  - request vector
//        i_ptr  - highest-priority requester index for this search
//        o_gnt  - one-hot grant (all zero when no request)
//        o_gnt_idx - binary index of the granted requester
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [PW-1:0]   o_gnt_idx
);

    logic          w_found;
    logic [PW-1:0] w_j;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_j       = '0;
        for (int k = 0; k < NREQ; k++) begin
            // Candidate k positions after the pointer, wrapping at NREQ.
            w_j = PW'((int'(i_ptr) + k) % NREQ);
            if (!w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_gnt_idx  = w_j;
            end
        end
    end

endmodule

// File: rtl/coproc_scheduler.sv
// Shares one add coprocessor among NREQ requesters: arbitrate, run, return result.
// Latency: add 3 cycles accept-to-response, bad opcode 1, timeout 1+TIMEOUT.
// Backpressure: response held until rsp_ready of the owner; no accept outside IDLE.
// Ports: req_*  - per-requester command channel (valid/ready, sliced operands)
//        rsp_*  - one-hot response channel with shared result/error
//        cp_*   - coprocessor operands, opcode, clear and result/ready
module coproc_scheduler
    import coproc_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int W       = 32,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_num1,
    input  logic [NREQ*W-1:0] req_num2,
    input  logic [NREQ*2-1:0] req_instr,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W-1:0]      rsp_result,
    output logic              rsp_error,
    output logic [W-1:0]      cp_num1,
    output logic [W-1:0]      cp_num2,
    output logic [1:0]        cp_instr,
    output logic              cp_clear_n,
    input  logic [W-1:0]      cp_result,
    input  logic              cp_ready
);

    localparam int PW = $clog2(NREQ);

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [NREQ-1:0] r_gnt;
    logic [W-1:0]    r_num1;
    logic [W-1:0]    r_num2;
    logic [1:0]      r_instr;
    logic [W-1:0]    r_result;
    logic            r_error;
    logic [7:0]      r_cnt;

    logic [NREQ-1:0] w_gnt;
    logic [PW-1:0]   w_gidx;
    logic            w_any;
    logic [W-1:0]    w_num1  [NREQ];
    logic [W-1:0]    w_num2  [NREQ];
    logic [1:0]      w_instr [NREQ];

    // Unpack the flat request buses so the winner can be selected by index.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_num1[gi]  = req_num1[gi*W +: W];
        assign w_num2[gi]  = req_num2[gi*W +: W];
        assign w_instr[gi] = req_instr[gi*2 +: 2];
    end

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .i_req     (req_valid),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gidx)
    );

    assign w_any = |req_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_gnt    <= '0;
            r_num1   <= '0;
            r_num2   <= '0;
            r_instr  <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt <= w_gnt;
                        r_ptr <= (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + PW'(1);
                        r_cnt <= '0;
                        if (w_instr[w_gidx] == OP_ADD) begin
                            // Operands reach the coprocessor only for a real add.
                            r_num1  <= w_num1[w_gidx];
                            r_num2  <= w_num2[w_gidx];
                            r_instr <= w_instr[w_gidx];
                            r_state <= WAIT;
                        end else begin
                            r_result <= '0;
                            r_error  <= 1'b1;
                            r_state  <= RESP;
                        end
                    end
                end
                WAIT: begin
                    // A ready in the final counted cycle still wins over timeout.
                    if (cp_ready) begin
                        r_result <= cp_result;
                        r_error  <= 1'b0;
                        r_state  <= RESP;
                    end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                        r_result <= '0;
                        r_error  <= 1'b1;
                        r_state  <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (|(rsp_ready & r_gnt)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Gated by reset so a pending request cannot show a grant while held in reset.
    assign req_ready  = (r_state == IDLE && !reset) ? w_gnt : '0;
    assign rsp_valid  = (r_state == RESP) ? r_gnt : '0;
    assign rsp_result = r_result;
    assign rsp_error  = r_error;
    // Clear is released only while waiting, so a stale ready never survives IDLE/RESP.
    assign cp_clear_n = (r_state == WAIT);
    assign cp_num1    = r_num1;
    assign cp_num2    = r_num2;
    assign cp_instr   = r_instr;

endmodule

// File: doc/coproc_scheduler.md
# coproc_scheduler

Controller that shares the single arithmetic coprocessor between NREQ requesters. It arbitrates round-robin, latches the winning operands, arms the coprocessor, waits for its ready flag with a timeout, and returns the result to the originating requester over a valid/ready response channel. It sits between the HPS-facing request ports and the coprocessor datapath, and is the only block that drives the coprocessor's inputs.

## Interface
- NREQ, 2: number of requesters, 2..4.
- W, 32: operand/result width.
- TIMEOUT, 15: maximum WAIT cycles before declaring an error, 1..255.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  requester i has a command.
- req_ready  out  NREQ  one-hot; command from requester i accepted this cycle.
- req_num1  in  NREQ*W  operand 1, slice i = [i*W +: W].
- req_num2  in  NREQ*W  operand 2, same slicing.
- req_instr  in  NREQ*2  opcode, slice i = [i*2 +: 2].
- rsp_valid  out  NREQ  one-hot; response for requester i.
- rsp_ready  in  NREQ  requester i takes the response.
- rsp_result  out  W  result, meaningful when any rsp_valid is high.
- rsp_error  out  1  1 = bad opcode or timeout; rsp_result is 0.
- cp_num1, cp_num2  out  W  operands to the coprocessor.
- cp_instr  out  2  opcode to the coprocessor.
- cp_clear_n  out  1  active-low clear of the coprocessor; low clears its ready flag.
- cp_result  in  W  coprocessor result.
- cp_ready  in  1  coprocessor result valid.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: cp_clear_n=0. If any req_valid, round-robin picks requester g starting from ptr; req_ready[g]=1 combinationally in the same cycle; operands, opcode, and g are latched; ptr becomes (g+1) mod NREQ.
  - Opcode 2'b01 (add): go to WAIT.
  - Any other opcode: go to RESP with rsp_error=1 and result 0. The coprocessor is not used.
- WAIT: cp_clear_n=1, with latched operands and opcode driven. The timeout counter starts at 0 and increments each cycle.
  - cp_ready=1: capture cp_result and go to RESP with error=0.
  - Counter reaches TIMEOUT-1 without ready: go to RESP with error=1 and result 0.
- RESP: cp_clear_n=0; rsp_valid[g]=1, and rsp_result/rsp_error are held stable. On rsp_ready[g], go to IDLE. rsp_ready on other bits is ignored.
- req_ready is 0 outside IDLE. A requester holding req_valid stays pending until it is granted.
- cp_ready is sampled only in WAIT. A stale high value seen in IDLE or RESP is ignored.
- Addition wraps modulo 2^W, as computed by the coprocessor. No carry is reported.

## Timing
- Reset values: state=IDLE, ptr=0, req_ready=0, rsp_valid=0, rsp_result=0, rsp_error=0, cp_clear_n=0, cp_num1=cp_num2=0, cp_instr=0.
- Add op:
  - Accept at cycle T.
  - WAIT at T+1, where the coprocessor computes at the end of T+1.
  - cp_ready is seen at T+2.
  - rsp_valid is asserted at T+3.
  - Accept-to-response latency is 3 cycles. Minimum issue interval is 4 cycles, with rsp_ready held high.
- Bad opcode: rsp_valid at T+1.
- Timeout: rsp_valid at T+1+TIMEOUT, with error=1.
- A response handshake and a new req_valid in the same RESP cycle: the new command is accepted no earlier than the next cycle, in IDLE.
- All requesters valid continuously: grants rotate 0,1,…,NREQ-1,0. No requester waits more than NREQ-1 other grants.
- Reset asserted mid-operation: immediate return to reset values. The in-flight command is dropped with no response, and cp_clear_n goes to 0 asynchronously.

## Structure
- Shared package coproc_pkg:
  - OP_ADD=2'b01.
  - State enum {IDLE, WAIT, RESP}.
  - Default TIMEOUT.
- Sub-module rr_arbiter:
  - Parameterised by NREQ.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant and binary index.
  - Purely combinational. The ptr register stays in coproc_scheduler.

## Test plan
- Single add: req0 sends 5+7 -> req_ready[0] at T, rsp_valid[0] at T+3, result 12, error 0.
- Wraparound: 0xFFFFFFFF+2 -> result 0x00000001, error 0.
- Fairness: both requesters valid continuously, each with distinct operands -> grants alternate 0,1,0,1, and each response goes to the correct one-hot bit with the matching sum.
- Bad opcode 2'b10 from req1 -> rsp_valid[1] at T+1, error 1, result 0, cp_clear_n never high.
- Timeout: model holds cp_ready=0 with TIMEOUT=15 -> rsp_valid at T+16, error 1. Response backpressure: rsp_ready held low for 10 cycles -> outputs stable, no new req_ready.
- Reset asserted during WAIT -> all outputs at reset values the same cycle, ptr=0, and no response for the dropped command after reset is released.
